// File: rtl/acu_alu_pkg.sv
// Shared types for the accumulator ALU with operand stack.
// Opcode encodings, FSM states and the stack pointer width helper.
package acu_alu_pkg;

    typedef enum logic [7:0] {
        OP_NOP = 8'h00,
        OP_LDI = 8'h01,
        OP_ADD = 8'h02,
        OP_SUB = 8'h03,
        OP_AND = 8'h04,
        OP_OR  = 8'h05,
        OP_XOR = 8'h06,
        OP_NOT = 8'h07,
        OP_SHL = 8'h08,
        OP_SHR = 8'h09,
        OP_MUL = 8'h0A
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    localparam int DEPTH_DEF = 8;
    localparam int PTR_W     = $clog2(DEPTH_DEF + 1);

    function automatic int ptr_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/acu_stack.sv
// LIFO operand stack: push, pop, or both at once (swap with ACC).
// Illegal requests raise a one-cycle err_o and leave the stack untouched.
module acu_stack
    import acu_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] tos_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             err_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    top_idx, wr_idx;
    logic             wr;

    assign full_o  = (ptr_q == PW'(DEPTH));
    assign empty_o = (ptr_q == '0);
    assign top_idx = AW'(ptr_q - PW'(1));
    assign tos_o   = mem_q[top_idx];

    assign err_o = en_i & ((pop_i & empty_o) | (push_i & ~pop_i & full_o));

    // A swap overwrites the current top instead of the next free slot
    assign wr     = en_i & push_i & ~err_o;
    assign wr_idx = pop_i ? top_idx : AW'(ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (en_i && !err_o) begin
            if (push_i && !pop_i) ptr_d = ptr_q + PW'(1);
            if (pop_i && !push_i) ptr_d = ptr_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_idx] <= din_i;
    end

endmodule

// File: rtl/acu_alu_stack.sv
// Accumulator ALU with shift-add multiplier, carry flag and operand stack.
// Define ACU_ALU_SAT_EN for unsigned saturating ADD/SUB.
module acu_alu_stack
    import acu_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             clr,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept, stk_cmd, stk_en, stk_bad;
    logic [WIDTH-1:0]   stk_tos;
    logic [WIDTH:0]     sum, dif, psum;
    logic [2*WIDTH-1:0] prod_step;

    assign op_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_MUL);
    assign accept   = op_valid & op_ready & ce;
    assign stk_cmd  = push | pop;
    assign stk_en   = ce & op_ready & ~accept & ~clr & stk_cmd;

    assign data_out = acc_q;
    assign zero     = (acc_q == '0);
    assign carry    = carry_q;
    assign stk_err  = err_q;

    assign sum = {1'b0, acc_q} + {1'b0, data_in};
    assign dif = {1'b0, acc_q} - {1'b0, data_in};

    // Multiplier in low half, partial product accumulates in high half
    assign psum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                     + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_step = {psum, prod_q[WIDTH-1:1]};

    acu_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .en_i    (stk_en),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (acc_q),
        .tos_o   (stk_tos),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .err_o   (stk_bad)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        err_d   = err_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            carry_d = 1'b0;
            err_d   = 1'b0;
            cnt_d   = '0;
        end else if (ce) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (stk_cmd) err_d = 1'b1;
                        case (op)
                            OP_LDI: acc_d = data_in;
                            OP_ADD: begin
                                carry_d = sum[WIDTH];
`ifdef ACU_ALU_SAT_EN
                                acc_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                                acc_d = sum[WIDTH-1:0];
`endif
                            end
                            OP_SUB: begin
                                carry_d = dif[WIDTH];
`ifdef ACU_ALU_SAT_EN
                                acc_d = dif[WIDTH] ? '0 : dif[WIDTH-1:0];
`else
                                acc_d = dif[WIDTH-1:0];
`endif
                            end
                            OP_AND: acc_d = acc_q & data_in;
                            OP_OR:  acc_d = acc_q | data_in;
                            OP_XOR: acc_d = acc_q ^ data_in;
                            OP_NOT: acc_d = ~acc_q;
                            OP_SHL: begin
                                carry_d = acc_q[WIDTH-1];
                                acc_d   = {acc_q[WIDTH-2:0], 1'b0};
                            end
                            OP_SHR: begin
                                carry_d = acc_q[0];
                                acc_d   = {1'b0, acc_q[WIDTH-1:1]};
                            end
                            OP_MUL: begin
                                mcand_d = acc_q;
                                prod_d  = {{WIDTH{1'b0}}, data_in};
                                cnt_d   = '0;
                                state_d = ST_MUL;
                            end
                            default: ;
                        endcase
                    end else if (stk_cmd) begin
                        if (stk_bad)  err_d = 1'b1;
                        else if (pop) acc_d = stk_tos;
                    end
                end
                ST_MUL: begin
                    if (stk_cmd) err_d = 1'b1;
                    prod_d = prod_step;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = ST_IDLE;
                        acc_d   = prod_step[WIDTH-1:0];
                        carry_d = |prod_step[2*WIDTH-1:WIDTH];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
